// File: rtl/ov_cfg_pkg.sv
// Shared types for the OV camera configuration sequencer: FSM encoding and
// the {addr, data} register-table entry format.
package ov_cfg_pkg;

  localparam int          ENTRY_W      = 24;
  localparam logic [15:0] DELAY_MARKER = 16'hFFFF;

  typedef enum logic [3:0] {
    S_PWDN,
    S_RST,
    S_SETTLE,
    S_FETCH,
    S_DELAY,
    S_ISSUE,
    S_WAIT,
    S_RETRY,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } cfg_entry_t;

endpackage

// File: rtl/ov_cfg_table.sv
// Register table for the sensor, one {addr, data} entry per index.
// Swap this file per sensor/resolution. Addr FFFF marks a delay entry.
module ov_cfg_table
  import ov_cfg_pkg::*;
#(
  parameter logic [7:0] REG_NUM = 8'd250
) (
  input  logic [7:0] cfg_idx,
  output cfg_entry_t entry
);

  always_comb begin
    entry = '0;
    if (cfg_idx < REG_NUM) begin
      case (cfg_idx)
        8'd0:    entry = {16'h3008, 8'h82};
        8'd1:    entry = {DELAY_MARKER, 8'h03};
        8'd2:    entry = {16'h3008, 8'h42};
        8'd3:    entry = {16'h3103, 8'h03};
        8'd4:    entry = {16'h3017, 8'hff};
        8'd5:    entry = {16'h3018, 8'hff};
        8'd6:    entry = {16'h3034, 8'h1a};
        8'd7:    entry = {16'h3037, 8'h13};
        8'd8:    entry = {16'h3108, 8'h01};
        8'd9:    entry = {16'h3630, 8'h36};
        8'd10:   entry = {16'h3631, 8'h0e};
        8'd11:   entry = {16'h3632, 8'he2};
        8'd12:   entry = {16'h3633, 8'h12};
        8'd13:   entry = {16'h3621, 8'he0};
        8'd14:   entry = {16'h3704, 8'ha0};
        8'd15:   entry = {16'h3703, 8'h5a};
        // Unfilled slots become zero-length delays so nothing is written.
        default: entry = {DELAY_MARKER, 8'h00};
      endcase
    end
  end

endmodule

// File: rtl/ov_cfg_sequencer.sv
// Camera power-up and SCCB register-configuration sequencer.
//
// state    | meaning
// S_PWDN   | camera powered down, waiting PWDN_WAIT
// S_RST    | powered, held in hardware reset for RST_WAIT
// S_SETTLE | reset released, waiting SETTLE_WAIT before first write
// S_FETCH  | latch table entry at cfg_idx
// S_DELAY  | delay entry, counting data*DLY_UNIT down to zero
// S_ISSUE  | pulse i2c_exec, clear timeout counter
// S_WAIT   | waiting for i2c_done or timeout
// S_RETRY  | reissue same entry or give up
// S_NEXT   | advance index or finish
// S_DONE   | all entries written, cfg_done held
// S_ERR    | retries exhausted, cfg_err held
module ov_cfg_sequencer
  import ov_cfg_pkg::*;
#(
  parameter logic [15:0] PWDN_WAIT    = 16'd1000,
  parameter logic [15:0] RST_WAIT     = 16'd1000,
  parameter logic [19:0] SETTLE_WAIT  = 20'd20000,
  parameter logic [7:0]  REG_NUM      = 8'd250,
  parameter logic [15:0] DLY_UNIT     = 16'd1000,
  parameter logic [15:0] DONE_TIMEOUT = 16'd50000,
  parameter logic [1:0]  MAX_RETRY    = 2'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reinit,
  output logic        i2c_exec,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  output logic        cam_pwdn,
  output logic        cam_rst_n,
  output logic [7:0]  cfg_idx,
  output logic        cfg_done,
  output logic        cfg_err
);

  state_t      state;
  logic [23:0] cnt;
  logic [23:0] cnt_inc;
  logic [23:0] dly_load;
  logic [1:0]  retry;
  cfg_entry_t  entry;

  ov_cfg_table #(
    .REG_NUM (REG_NUM)
  ) u_table (
    .cfg_idx (cfg_idx),
    .entry   (entry)
  );

  assign cnt_inc  = cnt + 24'd1;
  assign dly_load = 24'(entry.data) * 24'(DLY_UNIT);

  // One shared counter: power-up waits count up, delay entries count down,
  // and S_WAIT reuses it as the done timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_PWDN;
      cnt       <= '0;
      retry     <= '0;
      i2c_exec  <= 1'b0;
      i2c_addr  <= '0;
      i2c_data  <= '0;
      cfg_idx   <= '0;
      cam_pwdn  <= 1'b1;
      cam_rst_n <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      i2c_exec <= 1'b0;
      case (state)
        S_PWDN: begin
          if (cnt_inc >= 24'(PWDN_WAIT)) begin
            cnt      <= '0;
            cam_pwdn <= 1'b0;
            state    <= S_RST;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_RST: begin
          if (cnt_inc >= 24'(RST_WAIT)) begin
            cnt       <= '0;
            cam_rst_n <= 1'b1;
            state     <= S_SETTLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_SETTLE: begin
          if (cnt_inc >= 24'(SETTLE_WAIT)) begin
            cnt     <= '0;
            cfg_idx <= '0;
            retry   <= '0;
            state   <= S_FETCH;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_FETCH: begin
          i2c_addr <= entry.addr;
          i2c_data <= entry.data;
          if (entry.addr == DELAY_MARKER) begin
            cnt   <= dly_load;
            state <= S_DELAY;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_DELAY: begin
          if (cnt == '0) state <= S_NEXT;
          else           cnt   <= cnt - 24'd1;
        end
        S_ISSUE: begin
          i2c_exec <= 1'b1;
          cnt      <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // done takes priority over a coincident timeout
          if (i2c_done)                          state <= i2c_ack ? S_RETRY : S_NEXT;
          else if (cnt >= 24'(DONE_TIMEOUT))     state <= S_RETRY;
          else                                   cnt   <= cnt_inc;
        end
        S_RETRY: begin
          if (retry < MAX_RETRY) begin
            retry <= retry + 2'd1;
            state <= S_ISSUE;
          end else begin
            cfg_err <= 1'b1;
            state   <= S_ERR;
          end
        end
        S_NEXT: begin
          if (cfg_idx == REG_NUM - 8'd1) begin
            cfg_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            cfg_idx <= cfg_idx + 8'd1;
            retry   <= '0;
            state   <= S_FETCH;
          end
        end
        S_DONE, S_ERR: begin
          if (reinit) begin
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_idx   <= '0;
            retry     <= '0;
            cnt       <= '0;
            cam_pwdn  <= 1'b1;
            cam_rst_n <= 1'b0;
            state     <= S_PWDN;
          end
        end
        default: state <= S_PWDN;
      endcase
    end
  end

endmodule

// File: tb/tb_ov_cfg_sequencer.sv
// Bench for ov_cfg_sequencer: driver model with programmable ack, scoreboard of
// expected SCCB writes, directed timing checks on two parameterisations.
`timescale 1ns/1ps
module tb_ov_cfg_sequencer;

  localparam int          LAT   = 5;
  localparam int          UNIT  = 10;
  localparam int          TMO   = 20;
  localparam logic [23:0] E0    = 24'h3008_82;
  localparam logic [23:0] E2    = 24'h3008_42;
  localparam logic [23:0] E3    = 24'h3103_03;
  localparam int          DLY1  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance a: MAX_RETRY=3, instance b: MAX_RETRY=1
  logic        rst_n_a, reinit_a, exec_a, done_a, ack_a, pwdn_a, camrst_a, cdone_a, cerr_a;
  logic [15:0] addr_a;
  logic [7:0]  data_a, idx_a;
  logic        rst_n_b, reinit_b, exec_b, done_b, ack_b, pwdn_b, camrst_b, cdone_b, cerr_b;
  logic [15:0] addr_b;
  logic [7:0]  data_b, idx_b;

  logic drv_done = 1'b0, drv_ack = 1'b0, stray_done, drv_kill;
  assign done_a = drv_done | stray_done;
  assign ack_a  = drv_ack;

  ov_cfg_sequencer #(
    .PWDN_WAIT(16'd4), .RST_WAIT(16'd4), .SETTLE_WAIT(20'd8), .REG_NUM(8'd4),
    .DLY_UNIT(16'(UNIT)), .DONE_TIMEOUT(16'(TMO)), .MAX_RETRY(2'd3)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .reinit(reinit_a), .i2c_exec(exec_a),
    .i2c_addr(addr_a), .i2c_data(data_a), .i2c_done(done_a), .i2c_ack(ack_a),
    .cam_pwdn(pwdn_a), .cam_rst_n(camrst_a), .cfg_idx(idx_a),
    .cfg_done(cdone_a), .cfg_err(cerr_a)
  );

  ov_cfg_sequencer #(
    .PWDN_WAIT(16'd4), .RST_WAIT(16'd4), .SETTLE_WAIT(20'd8), .REG_NUM(8'd4),
    .DLY_UNIT(16'(UNIT)), .DONE_TIMEOUT(16'(TMO)), .MAX_RETRY(2'd1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .reinit(reinit_b), .i2c_exec(exec_b),
    .i2c_addr(addr_b), .i2c_data(data_b), .i2c_done(done_b), .i2c_ack(ack_b),
    .cam_pwdn(pwdn_b), .cam_rst_n(camrst_b), .cfg_idx(idx_b),
    .cfg_done(cdone_b), .cfg_err(cerr_b)
  );

  int cyc_a = 0, cyc_b = 0;
  always @(posedge clk) cyc_a <= rst_n_a ? cyc_a + 1 : 0;
  always @(posedge clk) cyc_b <= rst_n_b ? cyc_b + 1 : 0;

  logic [23:0] sb_a[$];
  logic        ack_q[$];
  int          exec_cyc[$], done_cyc[$], idx_at_exec[$], exec_b_cyc[$];
  logic [23:0] exp_v;
  int          pend = 0;

  // SCCB driver model: done LAT cycles after exec, ack from ack_q (default 0)
  always @(negedge clk) begin
    drv_done = 1'b0;
    if (drv_kill) pend = 0;
    else if (exec_a) pend = LAT;
    else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        drv_done = 1'b1;
        drv_ack  = (ack_q.size() > 0) ? ack_q.pop_front() : 1'b0;
        done_cyc.push_back(cyc_a);
      end
    end
  end

  always @(negedge clk) begin
    if (exec_a) begin
      exec_cyc.push_back(cyc_a);
      idx_at_exec.push_back(int'(idx_a));
      total++;
      assert (sb_a.size() > 0) else begin
        bad++;
        $error("FAIL exec_a_unexpected: observed=%h expected=none", {addr_a, data_a});
      end
      if (sb_a.size() > 0) begin
        exp_v = sb_a.pop_front();
        total++;
        assert ({addr_a, data_a} === exp_v) else begin
          bad++;
          $error("FAIL exec_a_payload: observed=%h expected=%h", {addr_a, data_a}, exp_v);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (exec_b) begin
      exec_b_cyc.push_back(cyc_b);
      total++;
      assert ({addr_b, data_b} === E0) else begin
        bad++;
        $error("FAIL exec_b_payload: observed=%h expected=%h", {addr_b, data_b}, E0);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_addr_data"}, 32'({addr_a, data_a}), 32'd0);
    chk({tag, "_idx"}, 32'(idx_a), 32'd0);
    chk({tag, "_ctrl"}, 32'({exec_a, pwdn_a, camrst_a, cdone_a, cerr_a}), 32'b01000);
  endtask

  task automatic clear_logs();
    exec_cyc.delete();
    done_cyc.delete();
    idx_at_exec.delete();
  endtask

  int pwdn_fall, rst_rise, done_rise, err_rise, r;

  initial begin
    rst_n_a = 0; rst_n_b = 0; reinit_a = 0; reinit_b = 0;
    stray_done = 0; drv_kill = 0; done_b = 0; ack_b = 0;
    repeat (3) @(negedge clk);
    chk_reset_a("reset");

    // power-up timing and table walk with a delay entry at index 1
    sb_a.push_back(E0); sb_a.push_back(E2); sb_a.push_back(E3);
    rst_n_a = 1;
    pwdn_fall = -1; rst_rise = -1; done_rise = -1;
    for (int i = 0; i < 400 && !cdone_a; i++) begin
      @(negedge clk);
      if (pwdn_fall < 0 && !pwdn_a) pwdn_fall = cyc_a;
      if (rst_rise < 0 && camrst_a) rst_rise = cyc_a;
      if (cdone_a) done_rise = cyc_a;
    end
    chk("pwdn_fall", pwdn_fall, 4);
    chk("rst_rise", rst_rise, 8);
    chk("exec_count", exec_cyc.size(), 3);
    chk("first_exec", exec_cyc[0], 18);
    // done->NEXT->FETCH->FETCH(load)->30 down-counts->zero->NEXT->FETCH->ISSUE->exec
    chk("delay_gap", exec_cyc[1] - done_cyc[0], 4 + DLY1 * UNIT + 3);
    chk("next_gap", exec_cyc[2] - done_cyc[1], 4);
    chk("done_rise", done_rise - done_cyc[2], 2);
    chk("err_a_clear", cerr_a, 0);
    chk("idx_final", idx_a, 3);
    chk("sb_a_empty", sb_a.size(), 0);

    // reinit from S_DONE, NACK twice on entry 0, reinit in S_WAIT ignored
    clear_logs();
    ack_q.push_back(1'b1); ack_q.push_back(1'b1);
    sb_a.push_back(E0); sb_a.push_back(E0); sb_a.push_back(E0);
    sb_a.push_back(E2); sb_a.push_back(E3);
    reinit_a = 1; r = cyc_a;
    @(negedge clk);
    reinit_a = 0;
    chk("reinit_clear", 32'({cdone_a, cerr_a, pwdn_a, camrst_a}), 32'b0010);
    chk("reinit_idx", idx_a, 0);
    for (int i = 0; i < 100 && !exec_a; i++) @(negedge clk);
    reinit_a = 1;
    @(negedge clk);
    reinit_a = 0;
    chk("reinit_ignored", 32'({pwdn_a, camrst_a}), 32'b01);
    chk("first_exec_reinit", exec_cyc[0] - (r + 1), 18);
    for (int i = 0; i < 400 && !cdone_a; i++) @(negedge clk);
    chk("nack_exec_count", exec_cyc.size(), 5);
    chk("retry_gap", exec_cyc[1] - done_cyc[0], 3);
    chk("idx_third_try", idx_at_exec[2], 0);
    chk("idx_after_retry", idx_at_exec[3], 2);
    chk("nack_flags", 32'({cdone_a, cerr_a}), 32'b10);
    chk("sb_a_empty2", sb_a.size(), 0);

    // one-cycle reset in S_WAIT followed by a stray done
    clear_logs();
    sb_a.push_back(E0);
    reinit_a = 1;
    @(negedge clk);
    reinit_a = 0;
    for (int i = 0; i < 100 && !exec_a; i++) @(negedge clk);
    rst_n_a = 0; drv_kill = 1;
    @(negedge clk);
    rst_n_a = 1; stray_done = 1;
    sb_a.push_back(E0); sb_a.push_back(E2); sb_a.push_back(E3);
    @(negedge clk);
    stray_done = 0; drv_kill = 0;
    chk_reset_a("after_stray");
    for (int i = 0; i < 400 && !cdone_a; i++) @(negedge clk);
    chk("rerun_exec_count", exec_cyc.size(), 4);
    chk("rerun_first_exec", exec_cyc[1], 18);
    chk("rerun_idx", idx_a, 3);
    chk("sb_a_empty3", sb_a.size(), 0);

    // instance b: driver never answers, one retry allowed
    rst_n_b = 1;
    err_rise = -1;
    for (int i = 0; i < 300 && !cerr_b; i++) begin
      @(negedge clk);
      if (cerr_b) err_rise = cyc_b;
    end
    chk("tmo_exec_count", exec_b_cyc.size(), 2);
    chk("tmo_first_exec", exec_b_cyc[0], 18);
    chk("tmo_gap", exec_b_cyc[1] - exec_b_cyc[0], TMO + 3);
    chk("tmo_err_rise", err_rise - exec_b_cyc[1], TMO + 2);
    chk("tmo_done_low", cdone_b, 0);
    repeat (30) @(negedge clk);
    chk("tmo_idle_execs", exec_b_cyc.size(), 2);
    chk("tmo_err_held", 32'({cerr_b, cdone_b, pwdn_b, camrst_b}), 32'b1001);
    reinit_b = 1;
    @(negedge clk);
    reinit_b = 0;
    chk("tmo_reinit", 32'({cerr_b, cdone_b, pwdn_b, camrst_b}), 32'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
